// File: rtl/seg_auth_pkg.sv
// seg_auth_pkg
//   Shared types and command codes for the BLE power-up authorisation path.
//   auth_state_t : authorisation FSM states (OFF, PWR1, PWR2)
//   rx_state_t   : UART receiver FSM states (IDLE, START, DATA, STOP)
//   CMD_GO       : 'g' command byte, requests power-up
//   CMD_STOP     : 's' command byte, requests stop

package seg_auth_pkg;

  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

endpackage

// File: rtl/ble_uart_rx_core.sv
// ble_uart_rx_core
//   8N1 UART receiver: 2-flop synchroniser, falling-edge start detect and a
//   mid-bit sampling FSM driven by a 13-bit down counter.
//   Parameter BAUD_DIV : clk cycles per bit
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous active-high reset
//     RX       in   asynchronous serial input, idles high
//     rx_byte  out  last byte received with a valid stop bit
//     rx_rdy   out  one-cycle pulse when rx_byte updates
//     rx_err   out  one-cycle pulse on a framing error

module ble_uart_rx_core
  import seg_auth_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       rx_err
);

  localparam logic [12:0] FULL_CNT = 13'(BAUD_DIV - 1);
  localparam logic [12:0] HALF_CNT = 13'(BAUD_DIV / 2 - 1);

  logic       rx_ff1, rx_ff2, rx_prev;
  logic       rx_fall;
  rx_state_t  state, state_nxt;
  logic [12:0] cnt, cnt_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [8:0] shreg, sh_nxt;
  logic [7:0] byte_nxt;
  logic       rdy_nxt, err_nxt;

  // Synchroniser and edge-detect flops preset high so reset never looks
  // like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
    end
  end

  assign rx_fall = rx_prev & ~rx_ff2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rx_byte <= '0;
      rx_rdy  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= sh_nxt;
      rx_byte <= byte_nxt;
      rx_rdy  <= rdy_nxt;
      rx_err  <= err_nxt;
    end
  end

  // The start bit is shifted in first, so after eight data bits it sits in
  // shreg[0] and the data byte occupies shreg[8:1].
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    byte_nxt  = rx_byte;
    rdy_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_fall) begin
          state_nxt = START;
          cnt_nxt   = HALF_CNT;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rx_ff2) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            cnt_nxt   = FULL_CNT;
            bit_nxt   = '0;
            sh_nxt    = {rx_ff2, shreg[8:1]};
          end
        end else begin
          cnt_nxt = cnt - 13'd1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          sh_nxt  = {rx_ff2, shreg[8:1]};
          bit_nxt = bit_cnt + 3'd1;
          cnt_nxt = FULL_CNT;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt - 13'd1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          if (rx_ff2 && !shreg[0]) begin
            byte_nxt = shreg[8:1];
            rdy_nxt  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 13'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/ble_auth_rx.sv
// ble_auth_rx
//   Decides whether the Segway may run from the BLE command stream.
//   'g' powers up; 's' stops, but only once the rider is off the platform.
//   Optional feature macro BLE_AUTH_WDOG_EN: link-loss watchdog in PWR1 that
//   acts like a received 's' after WDOG_CYCLES cycles without traffic.
//   Parameters: BAUD_DIV (clk cycles per bit), WDOG_CYCLES (watchdog only)
//   Ports:
//     clk        in   system clock
//     rst        in   synchronous active-high reset
//     RX         in   UART serial input, idles high
//     rider_off  in   high when load cells are below rider threshold
//     pwr_up     out  registered power-up authorisation
//     rx_byte    out  last byte received with a valid stop bit
//     rx_rdy     out  one-cycle pulse when rx_byte updates
//     rx_err     out  one-cycle pulse on a framing error

module ble_auth_rx
  import seg_auth_pkg::*;
#(
  parameter int BAUD_DIV = 5208
`ifdef BLE_AUTH_WDOG_EN
  , parameter logic [25:0] WDOG_CYCLES = 26'h3FFFFFF
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       rx_err
);

  auth_state_t state, state_nxt;
  logic        wdog_tc;
  logic        stop_evt;

  ble_uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_core (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .rx_byte (rx_byte),
    .rx_rdy  (rx_rdy),
    .rx_err  (rx_err)
  );

`ifdef BLE_AUTH_WDOG_EN
  localparam logic [25:0] WDOG_MAX = WDOG_CYCLES - 26'd1;
  logic [25:0] wdog_cnt;

  // Saturating link-loss counter; any traffic or state change restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
    end else if (rx_rdy || (state_nxt != state)) begin
      wdog_cnt <= '0;
    end else if ((state == PWR1) && !wdog_tc) begin
      wdog_cnt <= wdog_cnt + 26'd1;
    end
  end

  assign wdog_tc = (state == PWR1) && (wdog_cnt == WDOG_MAX);
`else
  assign wdog_tc = 1'b0;
`endif

  assign stop_evt = (rx_rdy && (rx_byte == CMD_STOP)) || wdog_tc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OFF;
      pwr_up <= 1'b0;
    end else begin
      state  <= state_nxt;
      pwr_up <= (state_nxt != OFF);
    end
  end

  // In PWR2 rider_off is checked first so it wins over a simultaneous 'g'.
  always_comb begin
    state_nxt = state;
    case (state)
      OFF: begin
        if (rx_rdy && (rx_byte == CMD_GO)) state_nxt = PWR1;
      end
      PWR1: begin
        if (stop_evt) state_nxt = rider_off ? OFF : PWR2;
      end
      PWR2: begin
        if (rider_off)                             state_nxt = OFF;
        else if (rx_rdy && (rx_byte == CMD_GO))    state_nxt = PWR1;
      end
      default: state_nxt = OFF;
    endcase
  end

endmodule

// File: tb/tb_ble_auth_rx.sv
// tb_ble_auth_rx
//   Directed testbench for ble_auth_rx with a short bit period. A UART
//   transmit task drives RX; a negedge monitor records rx_rdy/rx_err pulses,
//   the byte delivered and pwr_up around each rx_rdy.

module tb_ble_auth_rx;

  localparam int BAUD_DIV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       rider_off;
  logic       pwr_up;
  logic [7:0] rx_byte;
  logic       rx_rdy;
  logic       rx_err;

  int n_cmp  = 0;
  int n_fail = 0;

  int         rdy_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] rdy_byte = 8'h00;
  logic       pwr_at_rdy = 1'b0;
  logic       pwr_after = 1'b0;
  bit         grab_next = 1'b0;

  ble_auth_rx #(
    .BAUD_DIV(BAUD_DIV)
`ifdef BLE_AUTH_WDOG_EN
    , .WDOG_CYCLES(26'd1000)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .rider_off (rider_off),
    .pwr_up    (pwr_up),
    .rx_byte   (rx_byte),
    .rx_rdy    (rx_rdy),
    .rx_err    (rx_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (grab_next) pwr_after = pwr_up;
    grab_next = 1'b0;
    if (rx_rdy) begin
      rdy_cnt++;
      rdy_byte   = rx_byte;
      pwr_at_rdy = pwr_up;
      grab_next  = 1'b1;
    end
    if (rx_err) err_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    wait_cyc(BAUD_DIV);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_cyc(BAUD_DIV);
    end
    RX = stop_bit;
    wait_cyc(BAUD_DIV);
    RX = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; RX = 1'b1; rider_off = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    n_cmp++; if (pwr_up !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pwr_up: got %0b want 0", pwr_up); end
    n_cmp++; if (rx_byte !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rx_byte: got %h want 00", rx_byte); end
    n_cmp++; if (rx_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rx_rdy: got %0b want 0", rx_rdy); end
    n_cmp++; if (rx_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rx_err: got %0b want 0", rx_err); end
  endtask

  task automatic test_power_up();
    int base = rdy_cnt;
    send_byte(8'h67, 1'b1);
    wait_cyc(4);
    n_cmp++; if (rdy_cnt !== base + 1) begin n_fail++; $display("[TB] FAIL go_rdy_count: got %0d want %0d", rdy_cnt - base, 1); end
    n_cmp++; if (rdy_byte !== 8'h67) begin n_fail++; $display("[TB] FAIL go_byte: got %h want 67", rdy_byte); end
    n_cmp++; if (pwr_at_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL go_pwr_at_rdy: got %0b want 0", pwr_at_rdy); end
    n_cmp++; if (pwr_after !== 1'b1) begin n_fail++; $display("[TB] FAIL go_pwr_after: got %0b want 1", pwr_after); end
  endtask

  task automatic test_stop_rider_on();
    rider_off = 1'b0;
    send_byte(8'h73, 1'b1);
    wait_cyc(4);
    n_cmp++; if (rdy_byte !== 8'h73) begin n_fail++; $display("[TB] FAIL stop_on_byte: got %h want 73", rdy_byte); end
    n_cmp++; if (pwr_up !== 1'b1) begin n_fail++; $display("[TB] FAIL stop_on_pwr2_hold: got %0b want 1", pwr_up); end
    rider_off = 1'b1;
    wait_cyc(1);
    n_cmp++; if (pwr_up !== 1'b0) begin n_fail++; $display("[TB] FAIL stop_on_rider_off: got %0b want 0", pwr_up); end
  endtask

  task automatic test_stop_rider_off();
    rider_off = 1'b1;
    send_byte(8'h67, 1'b1);
    wait_cyc(4);
    n_cmp++; if (pwr_up !== 1'b1) begin n_fail++; $display("[TB] FAIL stop_off_go: got %0b want 1", pwr_up); end
    send_byte(8'h73, 1'b1);
    wait_cyc(4);
    n_cmp++; if (pwr_at_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL stop_off_pwr_at_rdy: got %0b want 1", pwr_at_rdy); end
    n_cmp++; if (pwr_after !== 1'b0) begin n_fail++; $display("[TB] FAIL stop_off_pwr_after: got %0b want 0", pwr_after); end
  endtask

  task automatic test_cancel_stop();
    rider_off = 1'b0;
    send_byte(8'h67, 1'b1);
    send_byte(8'h73, 1'b1);
    wait_cyc(4);
    send_byte(8'h67, 1'b1);
    wait_cyc(4);
    n_cmp++; if (pwr_up !== 1'b1) begin n_fail++; $display("[TB] FAIL cancel_pwr: got %0b want 1", pwr_up); end
    rider_off = 1'b1;
    wait_cyc(5);
    n_cmp++; if (pwr_up !== 1'b1) begin n_fail++; $display("[TB] FAIL cancel_pwr1_hold: got %0b want 1", pwr_up); end
    send_byte(8'h73, 1'b1);
    wait_cyc(4);
    n_cmp++; if (pwr_up !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_final_off: got %0b want 0", pwr_up); end
  endtask

  task automatic test_ignored_bytes();
    rider_off = 1'b0;
    send_byte(8'h73, 1'b1);
    send_byte(8'h41, 1'b1);
    wait_cyc(4);
    n_cmp++; if (rdy_byte !== 8'h41) begin n_fail++; $display("[TB] FAIL ignored_byte: got %h want 41", rdy_byte); end
    n_cmp++; if (pwr_up !== 1'b0) begin n_fail++; $display("[TB] FAIL ignored_pwr: got %0b want 0", pwr_up); end
  endtask

  task automatic test_frame_error();
    int r0 = rdy_cnt;
    int e0 = err_cnt;
    send_byte(8'h67, 1'b0);
    wait_cyc(BAUD_DIV);
    n_cmp++; if (err_cnt !== e0 + 1) begin n_fail++; $display("[TB] FAIL ferr_err_count: got %0d want 1", err_cnt - e0); end
    n_cmp++; if (rdy_cnt !== r0) begin n_fail++; $display("[TB] FAIL ferr_rdy_count: got %0d want 0", rdy_cnt - r0); end
    n_cmp++; if (rx_byte !== 8'h41) begin n_fail++; $display("[TB] FAIL ferr_byte_held: got %h want 41", rx_byte); end
    n_cmp++; if (pwr_up !== 1'b0) begin n_fail++; $display("[TB] FAIL ferr_pwr: got %0b want 0", pwr_up); end
    RX = 1'b0;
    wait_cyc(3);
    RX = 1'b1;
    wait_cyc(3 * BAUD_DIV);
    n_cmp++; if ((rdy_cnt !== r0) || (err_cnt !== e0 + 1)) begin n_fail++; $display("[TB] FAIL glitch_pulses: got rdy %0d err %0d want rdy 0 err 1", rdy_cnt - r0, err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    int r0 = rdy_cnt;
    rider_off = 1'b0;
    send_byte(8'h67, 1'b1);
    send_byte(8'h55, 1'b1);
    wait_cyc(4);
    n_cmp++; if (rdy_cnt !== r0 + 2) begin n_fail++; $display("[TB] FAIL b2b_rdy_count: got %0d want 2", rdy_cnt - r0); end
    n_cmp++; if (rdy_byte !== 8'h55) begin n_fail++; $display("[TB] FAIL b2b_byte: got %h want 55", rdy_byte); end
    n_cmp++; if (pwr_up !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_pwr: got %0b want 1", pwr_up); end
  endtask

  task automatic test_mid_reset();
    int r0 = rdy_cnt;
    RX = 1'b0;
    wait_cyc(BAUD_DIV);
    RX = 1'b1;
    wait_cyc(BAUD_DIV);
    RX = 1'b0;
    wait_cyc(5);
    rst = 1'b1;
    RX  = 1'b1;
    wait_cyc(1);
    n_cmp++; if (pwr_up !== 1'b0) begin n_fail++; $display("[TB] FAIL mrst_pwr_in_reset: got %0b want 0", pwr_up); end
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(12 * BAUD_DIV);
    n_cmp++; if ((rx_byte !== 8'h00) || (rdy_cnt !== r0)) begin n_fail++; $display("[TB] FAIL mrst_discard: got byte %h rdy %0d want byte 00 rdy 0", rx_byte, rdy_cnt - r0); end
    send_byte(8'h67, 1'b1);
    wait_cyc(4);
    n_cmp++; if (rdy_byte !== 8'h67) begin n_fail++; $display("[TB] FAIL mrst_byte: got %h want 67", rdy_byte); end
    n_cmp++; if (pwr_up !== 1'b1) begin n_fail++; $display("[TB] FAIL mrst_pwr: got %0b want 1", pwr_up); end
  endtask

  task automatic test_watchdog();
    rider_off = 1'b1;
    wait_cyc(1100);
`ifdef BLE_AUTH_WDOG_EN
    n_cmp++; if (pwr_up !== 1'b0) begin n_fail++; $display("[TB] FAIL wdog_timeout: got %0b want 0", pwr_up); end
`else
    n_cmp++; if (pwr_up !== 1'b1) begin n_fail++; $display("[TB] FAIL pwr1_hold: got %0b want 1", pwr_up); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    RX = 1'b1;
    rider_off = 1'b0;
    @(negedge clk);
    test_reset();
    test_power_up();
    test_stop_rider_on();
    test_stop_rider_off();
    test_cancel_stop();
    test_ignored_bytes();
    test_frame_error();
    test_back_to_back();
    test_mid_reset();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
